// File: rtl/draw_lines_pkg.sv
// rtl/draw_lines_pkg.sv - shared types and constants for the line frame sequencer
package draw_lines_pkg;

  localparam int X_COORD_W  = 11;
  localparam int Y_COORD_W  = 11;
  localparam int NUM_VERTS  = 8;
  localparam int VERT_IDX_W = $clog2(NUM_VERTS);
  localparam int NUM_EDGES  = 12;
  localparam int EDGE_IDX_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CLEAR     = 4'd1,
    ST_CLR_GUARD = 4'd2,
    ST_WAIT_CLR  = 4'd3,
    ST_FETCH     = 4'd4,
    ST_ISSUE     = 4'd5,
    ST_FIN_GUARD = 4'd6,
    ST_WAIT_FIN  = 4'd7,
    ST_DONE      = 4'd8
  } state_e;

  typedef struct packed {
    logic                  en;
    logic [VERT_IDX_W-1:0] v0;
    logic [VERT_IDX_W-1:0] v1;
  } edge_t;

endpackage

// File: rtl/line_frame_sequencer_if.sv
// rtl/line_frame_sequencer_if.sv - sequencer to draw_lines engine handshake bundle
interface line_frame_sequencer_if #(
  parameter int P_X_COORD_W = 11,
  parameter int P_Y_COORD_W = 11
);

  logic                   o_clear_buffer;
  logic                   o_load_fifo;
  logic [P_X_COORD_W-1:0] o_x0;
  logic [P_Y_COORD_W-1:0] o_y0;
  logic [P_X_COORD_W-1:0] o_x1;
  logic [P_Y_COORD_W-1:0] o_y1;
  logic                   i_waiting;
  logic                   i_fifo_full;

  // Sequencer side: drives clear/push and line endpoints, observes engine status.
  modport master (
    output o_clear_buffer, o_load_fifo, o_x0, o_y0, o_x1, o_y1,
    input  i_waiting, i_fifo_full
  );

  // Engine side.
  modport slave (
    input  o_clear_buffer, o_load_fifo, o_x0, o_y0, o_x1, o_y1,
    output i_waiting, i_fifo_full
  );

endinterface

// File: rtl/line_vertex_regfile.sv
// rtl/line_vertex_regfile.sv - projected vertex storage, one write port, two async read ports
module line_vertex_regfile
  import draw_lines_pkg::*;
#(
  parameter  int P_X_COORD_W = X_COORD_W,
  parameter  int P_Y_COORD_W = Y_COORD_W,
  parameter  int P_NUM_VERTS = NUM_VERTS,
  localparam int AW          = $clog2(P_NUM_VERTS)
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [P_X_COORD_W-1:0] i_wx,
  input  logic [P_Y_COORD_W-1:0] i_wy,
  input  logic [AW-1:0]          i_raddr0,
  input  logic [AW-1:0]          i_raddr1,
  output logic [P_X_COORD_W-1:0] o_rx0,
  output logic [P_Y_COORD_W-1:0] o_ry0,
  output logic [P_X_COORD_W-1:0] o_rx1,
  output logic [P_Y_COORD_W-1:0] o_ry1
);

  logic [P_X_COORD_W-1:0] x_q [P_NUM_VERTS];
  logic [P_X_COORD_W-1:0] x_d [P_NUM_VERTS];
  logic [P_Y_COORD_W-1:0] y_q [P_NUM_VERTS];
  logic [P_Y_COORD_W-1:0] y_d [P_NUM_VERTS];

  // Next-state of the vertex array: a single write lands at the addressed slot.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (i_we) begin
      x_d[i_waddr] = i_wx;
      y_d[i_waddr] = i_wy;
    end
  end

  // Vertex storage, cleared to the origin on reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      x_q <= '{default: '0};
      y_q <= '{default: '0};
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign o_rx0 = x_q[i_raddr0];
  assign o_ry0 = y_q[i_raddr0];
  assign o_rx1 = x_q[i_raddr1];
  assign o_ry1 = y_q[i_raddr1];

endmodule

// File: rtl/line_frame_sequencer.sv
// rtl/line_frame_sequencer.sv - frame controller: clear framebuffer, stream enabled edges, report done
module line_frame_sequencer
  import draw_lines_pkg::*;
#(
  parameter  int P_X_COORD_W = X_COORD_W,
  parameter  int P_Y_COORD_W = Y_COORD_W,
  parameter  int P_NUM_VERTS = NUM_VERTS,
  parameter  int P_NUM_EDGES = NUM_EDGES,
  localparam int VI_W        = $clog2(P_NUM_VERTS)
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_start,
  input  logic                   i_vert_we,
  input  logic [VI_W-1:0]        i_vert_addr,
  input  logic [P_X_COORD_W-1:0] i_vert_x,
  input  logic [P_Y_COORD_W-1:0] i_vert_y,
  input  logic                   i_edge_we,
  input  logic [EDGE_IDX_W-1:0]  i_edge_addr,
  input  logic [VI_W-1:0]        i_edge_v0,
  input  logic [VI_W-1:0]        i_edge_v1,
  input  logic                   i_edge_en,
  line_frame_sequencer_if.master eng,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic                   o_wr_err,
  output logic [4:0]             o_lines_issued
);

  // One extra bit so the index can reach P_NUM_EDGES (the end-of-table marker).
  localparam int CNT_W = 5;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       edge_idx_q, edge_idx_d;
  logic [CNT_W-1:0]       lines_q, lines_d;
  logic                   wr_err_q, wr_err_d;
  logic [P_X_COORD_W-1:0] x0_q, x0_d, x1_q, x1_d;
  logic [P_Y_COORD_W-1:0] y0_q, y0_d, y1_q, y1_d;
  edge_t                  edges_q [P_NUM_EDGES];
  edge_t                  edges_d [P_NUM_EDGES];

  edge_t                  cur_edge;
  logic                   vert_we;
  logic                   clear_pulse;
  logic                   load_pulse;
  logic                   done_pulse;
  logic [P_X_COORD_W-1:0] rx0, rx1;
  logic [P_Y_COORD_W-1:0] ry0, ry1;

  // Only consulted in FETCH while the index is still inside the table.
  assign cur_edge = edges_q[edge_idx_q[EDGE_IDX_W-1:0]];

  line_vertex_regfile #(
    .P_X_COORD_W (P_X_COORD_W),
    .P_Y_COORD_W (P_Y_COORD_W),
    .P_NUM_VERTS (P_NUM_VERTS)
  ) u_vertex_regfile (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_we      (vert_we),
    .i_waddr   (i_vert_addr),
    .i_wx      (i_vert_x),
    .i_wy      (i_vert_y),
    .i_raddr0  (cur_edge.v0),
    .i_raddr1  (cur_edge.v1),
    .o_rx0     (rx0),
    .o_ry0     (ry0),
    .o_rx1     (rx1),
    .o_ry1     (ry1)
  );

  // Table write gating plus frame FSM next-state and pulse outputs.
  always_comb begin
    state_d     = state_q;
    edge_idx_d  = edge_idx_q;
    lines_d     = lines_q;
    wr_err_d    = 1'b0;
    x0_d        = x0_q;
    y0_d        = y0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    edges_d     = edges_q;
    vert_we     = 1'b0;
    clear_pulse = 1'b0;
    load_pulse  = 1'b0;
    done_pulse  = 1'b0;

    // Tables are frozen for the whole frame; a write attempted then is dropped and flagged.
    if (state_q == ST_IDLE) begin
      vert_we = i_vert_we;
      if (i_edge_we && ({1'b0, i_edge_addr} < CNT_W'(P_NUM_EDGES))) begin
        edges_d[i_edge_addr] = '{en: i_edge_en, v0: i_edge_v0, v1: i_edge_v1};
      end
    end else begin
      wr_err_d = i_vert_we | i_edge_we;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d    = ST_CLEAR;
          edge_idx_d = '0;
          lines_d    = '0;
        end
      end
      ST_CLEAR: begin
        clear_pulse = 1'b1;
        state_d     = ST_CLR_GUARD;
      end
      // The engine needs a cycle to drop i_waiting after the clear request.
      ST_CLR_GUARD: state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: begin
        if (eng.i_waiting) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (edge_idx_q == CNT_W'(P_NUM_EDGES)) begin
          state_d = ST_FIN_GUARD;
        end else if (!cur_edge.en) begin
          edge_idx_d = edge_idx_q + CNT_W'(1);
        end else begin
          x0_d    = rx0;
          y0_d    = ry0;
          x1_d    = rx1;
          y1_d    = ry1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!eng.i_fifo_full) begin
          load_pulse = 1'b1;
          lines_d    = lines_q + CNT_W'(1);
          edge_idx_d = edge_idx_q + CNT_W'(1);
          state_d    = ST_FETCH;
        end
      end
      // Same reasoning as CLR_GUARD: let the last push register in the engine first.
      ST_FIN_GUARD: state_d = ST_WAIT_FIN;
      ST_WAIT_FIN: begin
        if (eng.i_waiting) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_pulse = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame state, counters, endpoint registers and edge table.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      edge_idx_q <= '0;
      lines_q    <= '0;
      wr_err_q   <= 1'b0;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      edges_q    <= '{default: '0};
    end else begin
      state_q    <= state_d;
      edge_idx_q <= edge_idx_d;
      lines_q    <= lines_d;
      wr_err_q   <= wr_err_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      edges_q    <= edges_d;
    end
  end

  assign eng.o_clear_buffer = clear_pulse;
  assign eng.o_load_fifo    = load_pulse;
  assign eng.o_x0           = x0_q;
  assign eng.o_y0           = y0_q;
  assign eng.o_x1           = x1_q;
  assign eng.o_y1           = y1_q;

  assign o_busy         = (state_q != ST_IDLE);
  assign o_frame_done   = done_pulse;
  assign o_wr_err       = wr_err_q;
  assign o_lines_issued = lines_q;

endmodule

// File: tb/tb_line_frame_sequencer.sv
// tb/tb_line_frame_sequencer.sv - scoreboard bench for line_frame_sequencer
module tb_line_frame_sequencer;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_vert_we;
  logic [2:0]  i_vert_addr;
  logic [10:0] i_vert_x, i_vert_y;
  logic        i_edge_we;
  logic [3:0]  i_edge_addr;
  logic [2:0]  i_edge_v0, i_edge_v1;
  logic        i_edge_en;
  logic        o_busy, o_frame_done, o_wr_err;
  logic [4:0]  o_lines_issued;

  line_frame_sequencer_if #(.P_X_COORD_W(11), .P_Y_COORD_W(11)) eng_if ();

  line_frame_sequencer dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_start        (i_start),
    .i_vert_we      (i_vert_we),
    .i_vert_addr    (i_vert_addr),
    .i_vert_x       (i_vert_x),
    .i_vert_y       (i_vert_y),
    .i_edge_we      (i_edge_we),
    .i_edge_addr    (i_edge_addr),
    .i_edge_v0      (i_edge_v0),
    .i_edge_v1      (i_edge_v1),
    .i_edge_en      (i_edge_en),
    .eng            (eng_if),
    .o_busy         (o_busy),
    .o_frame_done   (o_frame_done),
    .o_wr_err       (o_wr_err),
    .o_lines_issued (o_lines_issued)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_clear, n_push, n_done, exp_n;
  int push_cyc[$];
  logic [43:0] exp_q[$];

  logic [10:0] m_vx[8], m_vy[8];
  bit          m_en[12];
  logic [2:0]  m_v0[12], m_v1[12];
  int cube_a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int cube_b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every push and tallies pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_if.o_clear_buffer) n_clear++;
      if (o_frame_done) n_done++;
      if (eng_if.o_load_fifo) begin
        check("load_while_full", eng_if.i_fifo_full, 0);
        n_push++;
        push_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("push_with_empty_queue", exp_q.size(), 1);
        else check("push_coords", {eng_if.o_x0, eng_if.o_y0, eng_if.o_x1, eng_if.o_y1}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [43:0] exp_of(input int e);
    return {m_vx[m_v0[e]], m_vy[m_v0[e]], m_vx[m_v1[e]], m_vy[m_v1[e]]};
  endfunction

  task automatic write_vert(input int a, input logic [10:0] x, input logic [10:0] y);
    i_vert_we = 1; i_vert_addr = a[2:0]; i_vert_x = x; i_vert_y = y;
    m_vx[a] = x; m_vy[a] = y;
    tick();
    i_vert_we = 0;
  endtask

  task automatic write_edge(input int a, input bit en, input int v0, input int v1);
    i_edge_we = 1; i_edge_addr = a[3:0]; i_edge_en = en; i_edge_v0 = v0[2:0]; i_edge_v1 = v1[2:0];
    m_en[a] = en; m_v0[a] = v0[2:0]; m_v1[a] = v1[2:0];
    tick();
    i_edge_we = 0;
  endtask

  task automatic load_cube();
    for (int v = 0; v < 8; v++) write_vert(v, 11'($urandom), 11'($urandom));
    for (int e = 0; e < 12; e++) write_edge(e, 1, cube_a[e], cube_b[e]);
  endtask

  // Expected pushes follow straight from the model: every enabled edge, in table order.
  task automatic start_frame();
    exp_q.delete();
    exp_n = 0;
    for (int e = 0; e < 12; e++)
      if (m_en[e]) begin
        exp_q.push_back(exp_of(e));
        exp_n++;
      end
    n_clear = 0; n_push = 0; n_done = 0;
    push_cyc.delete();
    i_start = 1;
    tick();
    i_start = 0; i_vert_we = 0; i_edge_we = 0;
    check("clear_after_start", eng_if.o_clear_buffer, 1);
    check("busy_after_start", o_busy, 1);
    check("lines_zero_at_start", o_lines_issued, 0);
  endtask

  task automatic finish_checks();
    check("push_count", n_push, exp_n);
    check("queue_drained", exp_q.size(), 0);
    check("busy_after_done", o_busy, 0);
    check("done_count", n_done, 1);
    check("clear_count", n_clear, 1);
  endtask

  task automatic wait_done(input bit rand_full);
    bit got = 0;
    for (int t = 0; t < 3000 && !got; t++) begin
      if (rand_full) eng_if.i_fifo_full = ($urandom_range(0, 3) == 0);
      tick();
      got = o_frame_done;
    end
    eng_if.i_fifo_full = 0;
    check("frame_done_seen", got, 1);
    if (got) check("lines_issued", o_lines_issued, exp_n);
    tick();
    finish_checks();
  endtask

  task automatic wait_pushes(input int n);
    int t = 0;
    while (n_push < n && t < 500) begin
      tick();
      t++;
    end
    check("reached_push", n_push, n);
  endtask

  initial begin
    int sp_bad, stall_bad, done_seen;
    rst_n = 0; i_start = 0; i_vert_we = 0; i_vert_addr = 0; i_vert_x = 0; i_vert_y = 0;
    i_edge_we = 0; i_edge_addr = 0; i_edge_v0 = 0; i_edge_v1 = 0; i_edge_en = 0;
    eng_if.i_waiting = 1; eng_if.i_fifo_full = 0;
    for (int i = 0; i < 8; i++) begin m_vx[i] = 0; m_vy[i] = 0; end
    for (int i = 0; i < 12; i++) begin m_en[i] = 0; m_v0[i] = 0; m_v1[i] = 0; end

    #12;
    check("reset_outputs", {eng_if.o_clear_buffer, eng_if.o_load_fifo, o_busy, o_frame_done, o_wr_err,
                            o_lines_issued, eng_if.o_x0, eng_if.o_y0, eng_if.o_x1, eng_if.o_y1}, 0);
    tick();
    rst_n = 1;
    tick();
    check("idle_after_reset", {o_busy, o_frame_done, eng_if.o_clear_buffer}, 0);

    // Cube, all 12 edges enabled, pushes back to back.
    load_cube();
    start_frame();
    wait_done(0);
    sp_bad = 0;
    for (int i = 1; i < push_cyc.size(); i++) if (push_cyc[i] - push_cyc[i-1] != 2) sp_bad++;
    check("push_spacing", sp_bad, 0);

    // Edges 3 and 7 disabled, edge 0 collapsed to a zero-length line.
    write_edge(3, 0, cube_a[3], cube_b[3]);
    write_edge(7, 0, cube_a[7], cube_b[7]);
    write_edge(0, 1, 4, 4);
    start_frame();
    wait_done(0);
    check("ten_lines", o_lines_issued, 10);

    // FIFO full while edge 5 is pending.
    load_cube();
    start_frame();
    wait_pushes(5);
    eng_if.i_fifo_full = 1;
    stall_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (eng_if.o_load_fifo !== 1'b0) stall_bad++;
      if ({eng_if.o_x0, eng_if.o_y0, eng_if.o_x1, eng_if.o_y1} !== exp_of(5)) stall_bad++;
    end
    check("stall_hold", stall_bad, 0);
    eng_if.i_fifo_full = 0;
    #1;
    check("push_when_unstalled", eng_if.o_load_fifo, 1);
    wait_done(0);

    // Vertex write and restart attempt during a frame are both refused.
    start_frame();
    repeat (5) tick();
    i_vert_we = 1; i_vert_addr = 2; i_vert_x = ~m_vx[2]; i_vert_y = ~m_vy[2]; i_start = 1;
    tick();
    i_vert_we = 0; i_start = 0;
    check("wr_err_pulse", o_wr_err, 1);
    tick();
    check("wr_err_one_cycle", o_wr_err, 0);
    wait_done(0);

    // Engine stays busy for 50 cycles after the last push; vertex 2 must be unchanged.
    start_frame();
    wait_pushes(exp_n);
    eng_if.i_waiting = 0;
    done_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (o_frame_done) done_seen++;
    end
    check("no_done_while_engine_busy", done_seen, 0);
    eng_if.i_waiting = 1;
    tick();
    check("done_after_waiting", o_frame_done, 1);
    check("busy_in_done", o_busy, 1);
    check("lines_issued_late", o_lines_issued, exp_n);
    tick();
    check("done_one_cycle", o_frame_done, 0);
    finish_checks();

    // Randomized tables, fifo backpressure, and a vertex write in the start cycle.
    for (int f = 0; f < 4; f++) begin
      int a;
      for (int v = 0; v < 8; v++) write_vert(v, 11'($urandom), 11'($urandom));
      for (int e = 0; e < 12; e++)
        write_edge(e, $urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 7));
      a = $urandom_range(0, 7);
      i_vert_we = 1; i_vert_addr = a[2:0]; i_vert_x = 11'($urandom); i_vert_y = 11'($urandom);
      m_vx[a] = i_vert_x; m_vy[a] = i_vert_y;
      start_frame();
      wait_done(1);
    end

    // Reset while stalled in ISSUE: everything returns to reset values.
    load_cube();
    start_frame();
    wait_pushes(2);
    eng_if.i_fifo_full = 1;
    repeat (3) tick();
    check("stalled_before_reset", o_busy, 1);
    #2;
    rst_n = 0;
    #1;
    check("outputs_after_async_reset", {eng_if.o_clear_buffer, eng_if.o_load_fifo, o_busy, o_frame_done,
                                        o_wr_err, o_lines_issued, eng_if.o_x0, eng_if.o_y0,
                                        eng_if.o_x1, eng_if.o_y1}, 0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin m_vx[i] = 0; m_vy[i] = 0; end
    for (int i = 0; i < 12; i++) begin m_en[i] = 0; m_v0[i] = 0; m_v1[i] = 0; end
    tick();
    eng_if.i_fifo_full = 0;
    rst_n = 1;
    tick();
    start_frame();
    wait_done(0);
    check("no_lines_after_reset", o_lines_issued, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_frame_sequencer.md
# line_frame_sequencer

Frame-level controller for the line-drawing engine. It holds a small projected-vertex register file and an edge table (vertex-index pairs), and on each frame start it clears the line framebuffer. It then streams every enabled edge into the engine's line FIFO as (x0,y0,x1,y1) and reports frame completion. It sits between the 3D projection logic, which writes vertices, and the draw_lines engine, which owns the framebuffer and VGA readout.

## Interface
- P_X_COORD_W, 11, x coordinate width
- P_Y_COORD_W, 11, y coordinate width
- P_NUM_VERTS, 8, vertex register depth (power of 2)
- P_NUM_EDGES, 12, edge table depth (≤16)

- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle pulse, begin frame
- i_vert_we  in  1  vertex write strobe
- i_vert_addr  in  log2(P_NUM_VERTS)  vertex index
- i_vert_x / i_vert_y  in  P_X_COORD_W / P_Y_COORD_W  vertex screen coordinates
- i_edge_we  in  1  edge table write strobe
- i_edge_addr  in  4  edge index
- i_edge_v0 / i_edge_v1  in  log2(P_NUM_VERTS)  endpoint vertex indices
- i_edge_en  in  1  edge enabled
- i_waiting  in  1  engine idle, FIFO empty
- i_fifo_full  in  1  engine FIFO full
- o_clear_buffer  out  1  one-cycle clear pulse to engine
- o_load_fifo  out  1  one-cycle FIFO push
- o_x0, o_y0, o_x1, o_y1  out  coord widths  line endpoints, valid when o_load_fifo=1
- o_busy  out  1  frame in progress
- o_frame_done  out  1  one-cycle pulse, frame fully drawn
- o_wr_err  out  1  one-cycle pulse, table write dropped while busy
- o_lines_issued  out  5  lines pushed in the last or current frame

## Operation
- States: IDLE, CLEAR, CLR_GUARD, WAIT_CLR, FETCH, ISSUE, FIN_GUARD, WAIT_FIN, DONE.
- IDLE: accepts table writes. On i_start go to CLEAR, set o_busy, zero o_lines_issued and the edge index.
- CLEAR: assert o_clear_buffer for 1 cycle → CLR_GUARD (1 cycle, i_waiting ignored) → WAIT_CLR until i_waiting=1 → FETCH.
- FETCH: if edge index = P_NUM_EDGES, go to FIN_GUARD. Otherwise read the edge entry. If disabled, increment the index and stay in FETCH. If enabled, register both endpoints from the vertex file into o_x0..o_y1 and go to ISSUE.
- ISSUE: if i_fifo_full=0, assert o_load_fifo for 1 cycle, increment o_lines_issued and the edge index, then go to FETCH. If full, hold with coordinates stable and o_load_fifo=0.
- FIN_GUARD (1 cycle) → WAIT_FIN until i_waiting=1 → DONE.
- DONE: pulse o_frame_done, clear o_busy → IDLE.
- i_start while o_busy=1 is ignored; it is not queued.
- Table writes while o_busy=1 are dropped and o_wr_err pulses. Vertex and edge contents are therefore frame-stable.
- An edge with v0=v1 is issued as a zero-length line.
- If all edges are disabled, the frame is clear-only and o_lines_issued=0.
- Vertex and edge tables reset to 0; all edges are disabled at reset.

## Timing
- Async reset: state=IDLE; all outputs 0; tables cleared.
- o_clear_buffer is asserted the cycle after i_start is sampled.
- Each enabled edge costs 2 cycles (FETCH+ISSUE) when the FIFO is not full. Each disabled edge costs 1 cycle.
- o_load_fifo is never asserted in a cycle where i_fifo_full=1 is sampled.
- o_x0..o_y1 are registered and change only in FETCH. They hold through ISSUE stalls.
- o_frame_done comes ≥2 cycles after the last o_load_fifo, and only after i_waiting is sampled high.
- A table write and i_start in the same IDLE cycle: the write is committed and the frame uses the new value.
- Reset mid-frame aborts immediately. No further pulses are issued, and the engine is left to its own reset.

## Structure
- Package draw_lines_pkg:
  - state enum and encoding
  - coordinate width constants
  - edge-entry type {en, v0, v1}
- One sub-module: line_vertex_regfile. It is a P_NUM_VERTS-deep register file with one write port and two combinational read ports (v0, v1), with async active-low reset.
- The edge table and FSM live in line_frame_sequencer.

## Test plan
- Load a cube (8 vertices, 12 edges all enabled), pulse i_start, hold i_waiting=1 after the clear. Expect 1 clear pulse, 12 o_load_fifo pulses at 2-cycle spacing with correct endpoints, and o_lines_issued=12, followed by o_frame_done.
- Disable edges 3 and 7. Expect 10 pushes, skipping those endpoints, and o_lines_issued=10.
- Hold i_fifo_full=1 for 20 cycles during edge 5. Expect o_load_fifo=0 and stable coordinates, then a push on the first cycle the FIFO is not full.
- Write vertex 2 and pulse i_start while busy. Expect o_wr_err pulsed, the vertex unchanged, no restart, and exactly one o_frame_done.
- Keep i_waiting=0 for 50 cycles after the last push. Expect o_frame_done exactly 1 cycle after i_waiting rises and o_busy=0 the cycle after that.
- Assert i_reset_n=0 during ISSUE. Expect all outputs 0 immediately, state IDLE, and all edges disabled (a following i_start yields 0 lines).
